// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer and flush.
// Define PIPE_STAGE_STATS_EN to build the stall/bubble counters; otherwise they read 0.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] main_reg, main_next;
    logic [DATA_W-1:0] skid_reg, skid_next;
    logic              in_fire, out_fire;

    // Handshake outputs come straight from the state register: no combinational ready path.
    assign in_ready  = (state_reg != SKID);
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (Flush) begin
            state_next = EMPTY;
            main_next  = '0;
            skid_next  = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        main_next  = in_data;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end else if (in_fire) begin
                        // Downstream stalled while a transfer was in flight: park it.
                        skid_next  = in_data;
                        state_next = SKID;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_next  = skid_reg;
                        state_next = FULL;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // Index 0: stall cycles, index 1: bubble cycles. Both saturate and survive Flush.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc[0] = out_valid & ~out_ready;
    assign cnt_inc[1] = ~out_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != '1)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_cnt  = cnt_reg[0];
    assign bubble_cnt = cnt_reg[1];
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: reset, streaming, back-pressure, flush, reset priority, saturation.
module tb_pipe_stage_skid;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;
`ifdef PIPE_STAGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              Clk = 1'b0;
    logic              Reset, Flush;
    logic              in_valid, in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    pipe_stage_skid #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Flush      (Flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("  ok  %s = %0h", tag, got);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    // Expected counter value: hand-computed count when stats are built, 0 otherwise.
    function automatic logic [63:0] cx(input int v);
        return STATS ? 64'(v) : 64'd0;
    endfunction

    task automatic check_cnt(input string tag, input int stall_exp, input int bubble_exp);
        check_vec({tag, "_stall"},  64'(stall_cnt),  cx(stall_exp));
        check_vec({tag, "_bubble"}, 64'(bubble_cnt), cx(bubble_exp));
    endtask

    initial begin
        Reset = 1'b1; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        tick(2);
        check_vec("rst_out_valid", 64'(out_valid), 64'd0);
        check_vec("rst_in_ready",  64'(in_ready),  64'd1);
        check_vec("rst_out_data",  out_data,       64'd0);
        check_cnt("rst", 0, 0);

        Reset = 1'b0;
        tick(3);
        check_vec("idle_out_valid", 64'(out_valid), 64'd0);
        check_cnt("idle", 0, 3);

        // Streaming 1..4 with downstream always ready
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data = 64'(k);
            tick(1);
            check_vec($sformatf("stream%0d_data", k), out_data, 64'(k));
            check_vec($sformatf("stream%0d_valid", k), 64'(out_valid), 64'd1);
            check_vec($sformatf("stream%0d_in_ready", k), 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick(1);
        check_vec("drain_out_valid", 64'(out_valid), 64'd0);
        check_cnt("stream", 0, 4);

        // Back-pressure: A then B with downstream stalled
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA000_0000_0000_000A;
        tick(1);
        check_vec("bp_a_data", out_data, 64'hA000_0000_0000_000A);
        check_vec("bp_a_in_ready", 64'(in_ready), 64'd1);
        in_data = 64'h0B00_0000_0000_000B;
        tick(1);
        check_vec("bp_skid_in_ready", 64'(in_ready), 64'd0);
        check_vec("bp_skid_data", out_data, 64'hA000_0000_0000_000A);
        in_data = 64'hD;                       // must be refused while SKID
        tick(1);
        check_vec("bp_hold_in_ready", 64'(in_ready), 64'd0);
        check_vec("bp_hold_data", out_data, 64'hA000_0000_0000_000A);
        in_valid = 1'b0; out_ready = 1'b1;
        tick(1);
        check_vec("bp_b_data", out_data, 64'h0B00_0000_0000_000B);
        check_vec("bp_b_valid", 64'(out_valid), 64'd1);
        check_vec("bp_b_in_ready", 64'(in_ready), 64'd1);
        tick(1);
        check_vec("bp_empty_valid", 64'(out_valid), 64'd0);
        check_cnt("bp", 2, 5);

        // Flush while SKID, with a same-cycle input that must be dropped
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA;
        tick(1);
        in_data = 64'hB;
        tick(1);
        check_vec("fl_pre_in_ready", 64'(in_ready), 64'd0);
        Flush = 1'b1; in_data = 64'hC;
        tick(1);
        check_vec("fl_out_valid", 64'(out_valid), 64'd0);
        check_vec("fl_out_data",  out_data,       64'd0);
        check_vec("fl_in_ready",  64'(in_ready),  64'd1);
        Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(1);
        check_vec("fl_after_valid", 64'(out_valid), 64'd0);
        check_vec("fl_after_data",  out_data,       64'd0);
        check_cnt("fl", 4, 7);

        // Flush from EMPTY drops an input even though in_ready=1
        in_valid = 1'b1; in_data = 64'hE; out_ready = 1'b0; Flush = 1'b1;
        tick(1);
        check_vec("fle_out_valid", 64'(out_valid), 64'd0);
        check_vec("fle_out_data",  out_data,       64'd0);
        Flush = 1'b0; in_valid = 1'b0;
        tick(1);
        check_vec("fle_after_valid", 64'(out_valid), 64'd0);
        check_cnt("fle", 4, 9);

        // Reset beats Flush and a pending input
        in_valid = 1'b1; in_data = 64'hF;
        tick(1);
        check_vec("rf_load_data", out_data, 64'hF);
        Reset = 1'b1; Flush = 1'b1; in_data = 64'h11;
        tick(1);
        check_vec("rf_out_valid", 64'(out_valid), 64'd0);
        check_vec("rf_in_ready",  64'(in_ready),  64'd1);
        check_vec("rf_out_data",  out_data,       64'd0);
        check_cnt("rf", 0, 0);
        Reset = 1'b0; Flush = 1'b0;

        // Counter saturation at 2^CNT_W-1
        in_data = 64'h22;
        tick(1);
        in_valid = 1'b0;
        tick(20);
        check_vec("sat_hold_data", out_data, 64'h22);
        check_cnt("sat_stall", 15, 1);
        out_ready = 1'b1;
        tick(1);
        tick(20);
        check_vec("sat_idle_valid", 64'(out_valid), 64'd0);
        check_cnt("sat_bubble", 15, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. It replaces the fixed 64-bit fetch-to-decode latch between any two adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It adds back-pressure without a combinational ready path and bubble insertion on branch/hazard flush. Optional stall/bubble counters support pipeline performance analysis.

## Interface
Parameters:
- DATA_W, 64, payload width in bits (e.g. PC+4 concatenated with instruction).
- CNT_W, 16, width of each statistics counter.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  synchronous flush; discards all held entries and any same-cycle input.
- in_valid  input  1  upstream has a payload on in_data.
- in_ready  output  1  stage can accept; driven only from state registers.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data holds a valid payload.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  DATA_W  head payload (main register).
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  output  CNT_W  cycles with out_valid=0.

## Operation
- Storage: main register (drives out_data) and skid register, each DATA_W bits.
- in fire = in_valid & in_ready; out fire = out_valid & out_ready.
- States: EMPTY (no entries), FULL (main only), SKID (main and skid).
- in_ready = (state != SKID); out_valid = (state != EMPTY).
- EMPTY: in fire -> main <= in_data, go FULL; else stay.
- FULL: in fire & out fire -> main <= in_data, stay FULL; out fire only -> EMPTY; in fire only -> skid <= in_data, go SKID; neither -> hold.
- SKID: in_ready=0, no input accepted; out fire -> main <= skid, go FULL; else hold.
- Priority per edge: Reset > Flush > handshake.
- Flush: state <= EMPTY; main and skid <= 0; same-cycle in_data is dropped even when in_ready=1; same-cycle out fire is still considered consumed downstream.
- Payload passes unmodified; order is strictly FIFO.
- Data registers update only on the transitions above; otherwise they hold their value.

## Timing
- Reset values: state EMPTY, out_valid=0, in_ready=1, out_data=0, skid=0, stall_cnt=0, bubble_cnt=0.
- Latency: payload accepted on edge N is on out_data with out_valid=1 after edge N (1 cycle).
- Throughput: 1 payload/cycle sustained while out_ready=1.
- in_ready reacts to out_ready one cycle late; the skid entry absorbs the single in-flight transfer, so no payload is lost or duplicated.
- Flush while SKID: both entries discarded; after edge out_valid=0, in_ready=1.
- Reset mid-transfer: all entries discarded; Flush is ignored in a Reset cycle.
- Counters saturate at 2^CNT_W-1 and do not wrap. They are cleared only by Reset, not by Flush. They do not increment during a Reset cycle.

## Configuration
- PIPE_STAGE_STATS_EN defined: stall_cnt and bubble_cnt are implemented as described.
- Not defined: counter logic is not synthesised; stall_cnt and bubble_cnt are tied to 0. Port list and handshake behaviour are identical.

## Test plan
- Reset then idle: assert Reset 2 cycles, in_valid=0 -> out_valid=0, in_ready=1, out_data=0; with stats, bubble_cnt counts 1 per idle cycle after Reset deasserts.
- Streaming: out_ready=1, in_valid=1, in_data=1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, out_valid held 1, in_ready never 0.
- Back-pressure: send 0xA, 0xB with out_ready=0 -> state SKID, in_ready=0, out_data=0xA held. Raise out_ready -> 0xA then 0xB delivered in order; in_ready returns to 1 one cycle after the first out fire.
- Flush in SKID: hold 0xA/0xB, assert Flush with in_valid=1, in_data=0xC -> next cycle out_valid=0, out_data=0; 0xC never appears on the output.
- Reset beats Flush: Reset=1, Flush=1, in_valid=1 in the same cycle -> EMPTY, all outputs at reset values, counters 0.
- Counter saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; with the macro undefined, stall_cnt stays 0.
